// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: control FSM for the UART receive path.
// Synchronizes the serial line, validates the start bit at mid-bit and issues
// single-cycle strobes at the centre of every data, parity and stop bit.
// Optional feature macro: RX_PARITY_EN (adds the PARITY state and parity_load).
module uart_rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_in,
  input  logic rx_en,
  output logic rx_bit,
  output logic shift,
  output logic parity_load,
  output logic check_stop,
  output logic frame_done,
  output logic start_glitch,
  output logic busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IdxLast     = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_glitch;
  logic            w_glitch_next;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_in;
      r_sync2 <= r_sync1;
    end
  end

  assign rx_bit = r_sync2;

  // State, bit-timing counter, bit index and registered glitch pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_glitch <= w_glitch_next;
    end
  end

  // Next-state logic and mid-bit strobe decode.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + CntW'(1);
    w_idx_next    = r_idx;
    w_glitch_next = 1'b0;
    shift         = 1'b0;
    parity_load   = 1'b0;
    check_stop    = 1'b0;

    case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (rx_en && !r_sync2) begin
          w_state_next = StStart;
        end
      end
      StStart: begin
        if (r_cnt == CntHalfLast) begin
          w_cnt_next = '0;
          w_idx_next = '0;
          if (!r_sync2) begin
            w_state_next = StData;
          end else begin
            // Line went back high before mid start bit: treat as noise.
            w_state_next  = StIdle;
            w_glitch_next = 1'b1;
          end
        end
      end
      StData: begin
        if (r_cnt == CntLast) begin
          shift      = 1'b1;
          w_cnt_next = '0;
          w_idx_next = r_idx + 3'd1;
          if (r_idx == IdxLast) begin
`ifdef RX_PARITY_EN
            w_state_next = StParity;
`else
            w_state_next = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (r_cnt == CntLast) begin
          parity_load  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StStop;
        end
      end
`endif
      StStop: begin
        if (r_cnt == CntLast) begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          check_stop   = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StIdle;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  assign frame_done   = check_stop;
  assign start_glitch = r_glitch;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed self-checking bench for uart_rx_sequencer (CLKS_PER_BIT=16, DATA_BITS=8).
module tb_uart_rx_sequencer;

  localparam int CPB        = 16;
  localparam int DB         = 8;
  localparam int FirstShift = 25;
  localparam int ParOff     = 153;
`ifdef RX_PARITY_EN
  localparam int StopOff = 169;
`else
  localparam int StopOff = 153;
`endif

  logic CLK   = 1'b0;
  logic RST   = 1'b1;
  logic RX_in = 1'b1;
  logic rx_en = 1'b1;
  logic rx_bit, shift, parity_load, check_stop, frame_done, start_glitch, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Event log filled by the monitor; the initial block only reads it.
  int   sh_cyc[$];
  logic sh_bit[$];
  int   par_cyc[$];
  logic par_bit[$];
  int   stop_cyc[$];
  logic stop_bit[$];
  int   gl_cyc[$];
  int   rise_cyc[$];
  int   done_n    = 0;
  int   bad_done  = 0;
  int   multi     = 0;
  int   busy_last = -1;
  logic busy_prev = 1'b0;

  int b_sh, b_par, b_stop, b_gl, b_rise, b_done;

  uart_rx_sequencer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_in       (RX_in),
    .rx_en       (rx_en),
    .rx_bit      (rx_bit),
    .shift       (shift),
    .parity_load (parity_load),
    .check_stop  (check_stop),
    .frame_done  (frame_done),
    .start_glitch(start_glitch),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  // cyc equals the number of the most recent rising edge.
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (shift) begin
      sh_cyc.push_back(cyc);
      sh_bit.push_back(rx_bit);
    end
    if (parity_load) begin
      par_cyc.push_back(cyc);
      par_bit.push_back(rx_bit);
    end
    if (check_stop) begin
      stop_cyc.push_back(cyc);
      stop_bit.push_back(rx_bit);
    end
    if (frame_done) done_n++;
    if (frame_done !== check_stop) bad_done++;
    if (start_glitch) gl_cyc.push_back(cyc);
    if (int'(shift) + int'(parity_load) + int'(check_stop) + int'(start_glitch) > 1) multi++;
    if (busy && !busy_prev) rise_cyc.push_back(cyc);
    if (busy) busy_last = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic ql(input logic q[$], input int i);
    return (i < q.size()) ? q[i] : 1'bx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic snap();
    b_sh   = sh_cyc.size();
    b_par  = par_cyc.size();
    b_stop = stop_cyc.size();
    b_gl   = gl_cyc.size();
    b_rise = rise_cyc.size();
    b_done = done_n;
  endtask

  // Drives one even-parity frame; RST is pulsed for one cycle at step rst_at (-1: none).
  // k is the first rising edge that samples the start bit.
  task automatic drive_frame(input logic [7:0] data, input int rst_at, output int k);
    logic [10:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = data[i];
    nb = 1 + DB;
`ifdef RX_PARITY_EN
    bits[nb] = ^data;
    nb++;
`endif
    bits[nb] = 1'b1;
    nb++;
    k = cyc + 1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        RX_in = bits[b];
        RST   = (rst_at >= 0) && ((b * CPB + c) == rst_at);
        tick(1);
      end
    end
    RST   = 1'b0;
    RX_in = 1'b1;
  endtask

  // Checks one decoded frame against the log from the current bases, then advances them.
  task automatic check_frame(input int k, input logic [7:0] data);
    chk("busy_rise", qi(rise_cyc, b_rise), k + 2);
    for (int i = 0; i < DB; i++) begin
      chk($sformatf("shift%0d_cyc", i), qi(sh_cyc, b_sh + i), k + FirstShift + CPB * i);
      chk($sformatf("shift%0d_bit", i), ql(sh_bit, b_sh + i), data[i]);
    end
`ifdef RX_PARITY_EN
    chk("parity_cyc", qi(par_cyc, b_par), k + ParOff);
    chk("parity_bit", ql(par_bit, b_par), ^data);
    b_par++;
`endif
    chk("stop_cyc", qi(stop_cyc, b_stop), k + StopOff);
    chk("stop_bit", ql(stop_bit, b_stop), 1'b1);
    b_sh += DB;
    b_stop++;
    b_rise++;
    b_done++;
  endtask

  initial begin
    int k, k2;

    // Reset hold with idle line.
    RST   = 1'b1;
    RX_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("reset_hold%0d", i),
          {shift, parity_load, check_stop, frame_done, start_glitch, busy, rx_bit}, 7'b0000001);
    end
    RST = 1'b0;
    tick(3);

    // Single frame 0xA5.
    snap();
    drive_frame(8'hA5, -1, k);
    tick(4);
    check_frame(k, 8'hA5);
    chk("a5_shift_count", sh_cyc.size() - b_sh + DB, DB);
    chk("a5_done_count", done_n - b_done + 1, 1);
    chk("a5_busy_last", busy_last, k + StopOff);
    chk("a5_busy_idle", busy, 1'b0);
`ifndef RX_PARITY_EN
    chk("a5_no_parity", par_cyc.size() - b_par, 0);
`endif

    // Start-bit glitch: line low for 4 cycles.
    snap();
    RX_in = 1'b0;
    k = cyc + 1;
    tick(4);
    RX_in = 1'b1;
    tick(20);
    chk("glitch_count", gl_cyc.size() - b_gl, 1);
    chk("glitch_cyc", qi(gl_cyc, b_gl), k + 10);
    chk("glitch_no_shift", sh_cyc.size() - b_sh, 0);
    chk("glitch_busy", busy, 1'b0);

    // rx_en low keeps the FSM idle even with the line low.
    snap();
    rx_en = 1'b0;
    RX_in = 1'b0;
    tick(20);
    chk("disabled_no_busy", rise_cyc.size() - b_rise, 0);
    RX_in = 1'b1;
    tick(4);
    rx_en = 1'b1;
    tick(2);

    // Back-to-back frames with no idle gap.
    snap();
    drive_frame(8'h00, -1, k);
    drive_frame(8'hFF, -1, k2);
    tick(4);
    chk("b2b_shift_total", sh_cyc.size() - b_sh, 2 * DB);
    chk("b2b_done_total", done_n - b_done, 2);
    chk("b2b_no_glitch", gl_cyc.size() - b_gl, 0);
    check_frame(k, 8'h00);
    check_frame(k2, 8'hFF);

    // Reset one cycle after the 3rd shift; remaining line stays high.
    snap();
    drive_frame(8'hFD, 59, k);
    tick(4);
    chk("rst_shift_count", sh_cyc.size() - b_sh, 3);
    chk("rst_no_stop", stop_cyc.size() - b_stop, 0);
    chk("rst_no_parity", par_cyc.size() - b_par, 0);
    chk("rst_no_glitch", gl_cyc.size() - b_gl, 0);
    chk("rst_busy_last", busy_last, k + 58);
    chk("rst_busy", busy, 1'b0);

    // Normal frame after the reset.
    snap();
    drive_frame(8'h3C, -1, k);
    tick(4);
    check_frame(k, 8'h3C);
    chk("post_rst_shift_count", sh_cyc.size() - b_sh + DB, DB);

    chk("done_matches_stop", bad_done, 0);
    chk("single_strobe", multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
